// File: rtl/otter_intrpt_ctrl.sv
// otter_intrpt_ctrl: interrupt front end for the OTTER control unit.
// Synchronizes asynchronous request lines, latches rising edges into a
// pending register, offers the lowest-index enabled pending source to the
// control FSM and tracks the single in-service handler until mret.
// Optional build macro OTTER_INTRPT_LEVEL_EN: pending follows the
// synchronized request level instead of latching edges.
module otter_intrpt_ctrl #(
  parameter  int NUM_SRC     = 4,
  parameter  int SYNC_STAGES = 2,
  localparam int ID_W        = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic [NUM_SRC-1:0] irq_en,
  input  logic               glb_ie,
  input  logic               intrpt_taken,
  input  logic               intrpt_ret,
  output logic               intrpt_vld,
  output logic [ID_W-1:0]    intrpt_id,
  output logic [ID_W-1:0]    svc_id,
  output logic [NUM_SRC-1:0] pending,
  output logic               in_service
);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_SERVICE = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
  logic [NUM_SRC-1:0] sync_lvl;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] qual;
  logic [ID_W-1:0]    svc_id_q, svc_id_d;
  logic [ID_W-1:0]    sel_id;
  logic               accept;

  assign sync_lvl = sync_q[SYNC_STAGES-1];

  // Metastability chain: each request line is only used after the last stage.
  // NOTE: this small per-source flop array is reset like any other register so
  // that no stale request can leak out of reset; large RAMs would not be.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= irq_src;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  // Offer the lowest-index source that is both pending and enabled.
  // NOTE: combinational blocks use blocking '=' with defaults first, so no
  // latch is inferred and later loop iterations see earlier results.
  always_comb begin
    qual   = pending_q & irq_en;
    sel_id = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (qual[i]) sel_id = ID_W'(i);
    end
  end

  assign intrpt_vld = (|qual) && glb_ie && (state_q == ST_IDLE);
  assign accept     = intrpt_vld && intrpt_taken;

`ifdef OTTER_INTRPT_LEVEL_EN
  // Level mode: pending mirrors the synchronized request lines.
  always_comb begin
    pending_d = sync_lvl;
  end
`else
  logic [NUM_SRC-1:0] prev_q;
  logic [NUM_SRC-1:0] clr_mask;

  // Previous synchronized level, used for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_q <= '0;
    else        prev_q <= sync_lvl;
  end

  // Edge-latched pending: a new edge wins over the clear of an accepted source.
  always_comb begin
    clr_mask  = accept ? (NUM_SRC'(1) << sel_id) : '0;
    pending_d = (pending_q & ~clr_mask) | (sync_lvl & ~prev_q);
  end
`endif

  // Service FSM next state: enter on an accepted offer, leave on mret.
  always_comb begin
    state_d  = state_q;
    svc_id_d = svc_id_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d  = ST_SERVICE;
          svc_id_d = sel_id;
        end
      end
      ST_SERVICE: begin
        if (intrpt_ret) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, service id and pending registers.
  // NOTE: sequential state is updated with non-blocking '<=' only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      svc_id_q  <= '0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      svc_id_q  <= svc_id_d;
      pending_q <= pending_d;
    end
  end

  assign intrpt_id  = sel_id;
  assign svc_id     = svc_id_q;
  assign pending    = pending_q;
  assign in_service = (state_q == ST_SERVICE);

endmodule

// File: tb/tb_otter_intrpt_ctrl.sv
// Scoreboard bench for otter_intrpt_ctrl: a driver applies directed and
// random stimulus, predicts outputs from a behavioural model and queues
// them; an independent monitor pops and compares against the DUT.
module tb_otter_intrpt_ctrl;

  localparam int NUM_SRC = 4;
  localparam int S       = 2;
  localparam int ID_W    = 2;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [NUM_SRC-1:0] irq_src = '0;
  logic [NUM_SRC-1:0] irq_en = '0;
  logic               glb_ie = 1'b0;
  logic               intrpt_taken = 1'b0;
  logic               intrpt_ret = 1'b0;
  logic               intrpt_vld;
  logic [ID_W-1:0]    intrpt_id;
  logic [ID_W-1:0]    svc_id;
  logic [NUM_SRC-1:0] pending;
  logic               in_service;

  otter_intrpt_ctrl #(.NUM_SRC(NUM_SRC), .SYNC_STAGES(S)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .irq_src      (irq_src),
    .irq_en       (irq_en),
    .glb_ie       (glb_ie),
    .intrpt_taken (intrpt_taken),
    .intrpt_ret   (intrpt_ret),
    .intrpt_vld   (intrpt_vld),
    .intrpt_id    (intrpt_id),
    .svc_id       (svc_id),
    .pending      (pending),
    .in_service   (in_service)
  );

  always #5 clk = ~clk;

  typedef struct {
    string tag;
    int    vld;
    int    id;
    int    svc;
    int    pend;
    int    insvc;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;

  // Behavioural model: pending set, service flag and a history of sampled
  // request words (index 0 = most recent rising edge).
  logic [NUM_SRC-1:0] m_pend;
  bit                 m_act;
  int                 m_svc;
  logic [NUM_SRC-1:0] m_hist [0:S];

  task automatic check(input string name, input int act, input int exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  function automatic int lowest(input logic [NUM_SRC-1:0] v);
    for (int i = 0; i < NUM_SRC; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    m_pend = '0;
    m_act  = 0;
    m_svc  = 0;
    for (int k = 0; k <= S; k++) m_hist[k] = '0;
  endtask

  // Expected outputs for the present model state and present inputs.
  task automatic push_exp(input string tag);
    exp_t e;
    logic [NUM_SRC-1:0] q;
    q       = m_pend & irq_en;
    e.tag   = tag;
    e.vld   = ((q != 0) && glb_ie && !m_act) ? 1 : 0;
    e.id    = lowest(q);
    e.svc   = m_svc;
    e.pend  = int'(m_pend);
    e.insvc = m_act ? 1 : 0;
    sbq.push_back(e);
  endtask

  // Advance the model across one rising clock edge with the present inputs.
  task automatic advance();
    logic [NUM_SRC-1:0] q;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] clr;
    bit acc;
    int id;
    q    = m_pend & irq_en;
    acc  = (q != 0) && glb_ie && !m_act && intrpt_taken;
    id   = lowest(q);
    rise = m_hist[S-1] & ~m_hist[S];
    clr  = acc ? NUM_SRC'(1 << id) : '0;
`ifdef OTTER_INTRPT_LEVEL_EN
    m_pend = m_hist[S-1];
`else
    m_pend = (m_pend & ~clr) | rise;
`endif
    if (acc) begin
      m_act = 1;
      m_svc = id;
    end else if (m_act && intrpt_ret) begin
      m_act = 0;
    end
    for (int k = S; k >= 1; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = irq_src;
  endtask

  task automatic step(input logic [NUM_SRC-1:0] src, input logic [NUM_SRC-1:0] en,
                      input logic gie, input logic tk, input logic rt, input string tag);
    @(negedge clk);
    irq_src      = src;
    irq_en       = en;
    glb_ie       = gie;
    intrpt_taken = tk;
    intrpt_ret   = rt;
    #1;
    push_exp(tag);
    advance();
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before any edge.
  task automatic do_reset(input string tag);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    model_reset();
    push_exp(tag);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: compares every queued expectation against the DUT.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      while (sbq.size() > 0) begin
        exp_t e;
        e = sbq.pop_front();
        check({e.tag, ".vld"},   int'(intrpt_vld), e.vld);
        check({e.tag, ".id"},    int'(intrpt_id),  e.id);
        check({e.tag, ".svc"},   int'(svc_id),     e.svc);
        check({e.tag, ".pend"},  int'(pending),    e.pend);
        check({e.tag, ".insvc"}, int'(in_service), e.insvc);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NUM_SRC-1:0] src, en;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single edge on source 2 offered with id 2.
    repeat (3) step(4'b0000, 4'hF, 1, 0, 0, "idle");
    repeat (6) step(4'b0100, 4'hF, 1, 0, 0, "edge2");
    step(4'b0100, 4'hF, 1, 1, 0, "take2");
    repeat (2) step(4'b0100, 4'hF, 1, 0, 0, "svc2");
    step(4'b0000, 4'hF, 1, 0, 1, "ret2");
    repeat (2) step(4'b0000, 4'hF, 1, 0, 0, "idle2");

    // Sources 1 and 3 pending: 1 served first, then 3 offered.
    step(4'b1010, 4'hF, 0, 0, 0, "p13");
    repeat (4) step(4'b0000, 4'hF, 0, 1, 0, "p13_gie0");
    step(4'b0000, 4'hF, 1, 1, 0, "take1");
    repeat (2) step(4'b0000, 4'hF, 1, 1, 0, "svc1");
    step(4'b0000, 4'hF, 1, 0, 1, "ret1");
    step(4'b0000, 4'hF, 1, 0, 1, "offer3");
    step(4'b0000, 4'hF, 1, 1, 0, "take3");
    step(4'b0000, 4'hF, 1, 0, 1, "ret3");

    // Masked pending source becomes visible the cycle its enable rises.
    step(4'b0010, 4'h0, 1, 0, 0, "mask");
    repeat (3) step(4'b0000, 4'h0, 1, 1, 0, "mask_hold");
    step(4'b0000, 4'b0010, 1, 0, 0, "en_on");
    step(4'b0000, 4'b0010, 1, 1, 0, "take_m");
    step(4'b0000, 4'b0010, 1, 0, 1, "ret_m");

    // New edge on source 0 on the same edge it is taken.
    step(4'b0001, 4'hF, 1, 0, 0, "c0");
    repeat (3) step(4'b0000, 4'hF, 1, 0, 0, "c0_wait");
    step(4'b0001, 4'hF, 1, 0, 0, "c0_rise");
    step(4'b0001, 4'hF, 1, 0, 0, "c0_sync");
    step(4'b0001, 4'hF, 1, 1, 0, "coll");
    step(4'b0001, 4'hF, 1, 0, 0, "coll_after");
    step(4'b0000, 4'hF, 1, 0, 1, "coll_ret");
    repeat (2) step(4'b0000, 4'hF, 1, 0, 0, "coll_idle");

    // Reset while in service, source 3 held high through release.
    step(4'b1000, 4'hF, 1, 0, 0, "rs_rise");
    repeat (3) step(4'b1000, 4'hF, 1, 0, 0, "rs_wait");
    step(4'b1000, 4'hF, 1, 1, 0, "rs_take");
    step(4'b1000, 4'hF, 1, 0, 0, "rs_svc");
    do_reset("rst_mid");
    repeat (5) step(4'b1000, 4'hF, 1, 0, 0, "rs_after");
    step(4'b1000, 4'hF, 1, 1, 0, "rs_take2");
    step(4'b1000, 4'hF, 1, 0, 1, "rs_ret2");
    repeat (4) step(4'b1000, 4'hF, 1, 0, 0, "rs_quiet");

    // Randomized traffic.
    src = '0;
    en  = 4'hF;
    for (int n = 0; n < 3000; n++) begin
      src ^= NUM_SRC'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 15) == 0) en = NUM_SRC'($urandom);
      if ($urandom_range(0, 599) == 0) do_reset("rnd_rst");
      step(src, en, ($urandom_range(0, 7) != 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 3) == 0), "rnd");
    end

    repeat (3) @(negedge clk);
    #3;
    check("scoreboard_drain", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
